// File: rtl/traffic_light_pkg.sv
// rtl/traffic_light_pkg.sv - light encodings, phase and error codes shared by the traffic-light controller and monitor
package traffic_light_pkg;

  localparam logic [1:0] GREEN  = 2'b10;
  localparam logic [1:0] YELLOW = 2'b01;
  localparam logic [1:0] RED    = 2'b00;

  localparam logic [2:0] PH_MG   = 3'd0;
  localparam logic [2:0] PH_MY   = 3'd1;
  localparam logic [2:0] PH_SG   = 3'd2;
  localparam logic [2:0] PH_SY   = 3'd3;
  localparam logic [2:0] PH_PED  = 3'd4;
  localparam logic [2:0] PH_NONE = 3'd7;

  localparam logic [2:0] ERR_NONE    = 3'd0;
  localparam logic [2:0] ERR_ILLEGAL = 3'd1;
  localparam logic [2:0] ERR_ORDER   = 3'd2;
  localparam logic [2:0] ERR_SHORT   = 3'd3;
  localparam logic [2:0] ERR_LONG    = 3'd4;

  typedef enum logic {
    MON_SYNC  = 1'b0,
    MON_TRACK = 1'b1
  } mon_state_t;

  // Legal phase sequence MG -> MY -> SG -> SY -> PED -> MG.
  function automatic logic [2:0] next_phase(input logic [2:0] ph);
    case (ph)
      PH_MG:   next_phase = PH_MY;
      PH_MY:   next_phase = PH_SG;
      PH_SG:   next_phase = PH_SY;
      PH_SY:   next_phase = PH_PED;
      PH_PED:  next_phase = PH_MG;
      default: next_phase = PH_NONE;
    endcase
  endfunction

endpackage

// File: rtl/traffic_phase_decode.sv
// rtl/traffic_phase_decode.sv - combinational decode of the light bus into a phase code
module traffic_phase_decode
  import traffic_light_pkg::*;
(
  input  logic [1:0] main_street,
  input  logic [1:0] side_street,
  input  logic       pedestrian_light,
  output logic [2:0] phase
);

  always_comb begin
    phase = PH_NONE;
    if (main_street == GREEN && side_street == RED && !pedestrian_light)
      phase = PH_MG;
    else if (main_street == YELLOW && side_street == RED && !pedestrian_light)
      phase = PH_MY;
    else if (main_street == RED && side_street == GREEN && !pedestrian_light)
      phase = PH_SG;
    else if (main_street == RED && side_street == YELLOW && !pedestrian_light)
      phase = PH_SY;
    else if (main_street == RED && side_street == RED && pedestrian_light)
      phase = PH_PED;
  end

endmodule

// File: rtl/traffic_light_monitor.sv
// rtl/traffic_light_monitor.sv - passive checker of phase order and dwell time on the traffic-light bus
module traffic_light_monitor
  import traffic_light_pkg::*;
#(
  parameter int MIN_DWELL = 3,
  parameter int MAX_DWELL = 3,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       main_street,
  input  logic [1:0]       side_street,
  input  logic             pedestrian_light,
  input  logic             clear_err,
  output logic [2:0]       phase,
  output logic             in_sync,
  output logic             violation,
  output logic             err_sticky,
  output logic [2:0]       err_code,
  output logic [CNT_W-1:0] cycle_count
);

  localparam int DW = $clog2(MAX_DWELL + 2);
  localparam logic [DW-1:0] DWELL_ONE = DW'(1);
  localparam logic [DW-1:0] DWELL_MIN = DW'(MIN_DWELL);
  localparam logic [DW-1:0] DWELL_MAX = DW'(MAX_DWELL);
  localparam logic [DW-1:0] DWELL_SAT = DW'(MAX_DWELL + 1);

  logic [2:0]       dec_phase;
  mon_state_t       state_q, state_d;
  logic [2:0]       phase_q;
  logic [DW-1:0]    dwell_q, dwell_d;
  logic             first_q, first_d;
  logic             viol_q, viol_d;
  logic [2:0]       new_err;
  logic             sticky_q, sticky_d;
  logic [2:0]       code_q, code_d;
  logic [CNT_W-1:0] cycle_q, cycle_d;

  traffic_phase_decode u_decode (
    .main_street      (main_street),
    .side_street      (side_street),
    .pedestrian_light (pedestrian_light),
    .phase            (dec_phase)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= MON_SYNC;
      phase_q  <= PH_NONE;
      dwell_q  <= '0;
      first_q  <= 1'b0;
      viol_q   <= 1'b0;
      sticky_q <= 1'b0;
      code_q   <= ERR_NONE;
      cycle_q  <= '0;
    end else begin
      state_q  <= state_d;
      phase_q  <= dec_phase;
      dwell_q  <= dwell_d;
      first_q  <= first_d;
      viol_q   <= viol_d;
      sticky_q <= sticky_d;
      code_q   <= code_d;
      cycle_q  <= cycle_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dwell_d = dwell_q;
    first_d = first_q;
    viol_d  = 1'b0;
    new_err = ERR_NONE;
    cycle_d = cycle_q;
    if (state_q == MON_SYNC) begin
      if (dec_phase != PH_NONE) begin
        state_d = MON_TRACK;
        dwell_d = DWELL_ONE;
        first_d = 1'b1;
      end
    end else if (dec_phase == PH_NONE) begin
      viol_d  = 1'b1;
      new_err = ERR_ILLEGAL;
      state_d = MON_SYNC;
      dwell_d = '0;
      first_d = 1'b0;
    end else if (dec_phase == phase_q) begin
      // Saturating one past the limit makes LONG fire once per occurrence.
      if (dwell_q != DWELL_SAT)
        dwell_d = dwell_q + DWELL_ONE;
      if (dwell_q == DWELL_MAX) begin
        viol_d  = 1'b1;
        new_err = ERR_LONG;
      end
    end else if (dec_phase != next_phase(phase_q)) begin
      viol_d  = 1'b1;
      new_err = ERR_ORDER;
      dwell_d = DWELL_ONE;
      first_d = 1'b1;
    end else begin
      if (dwell_q < DWELL_MIN && !first_q) begin
        viol_d  = 1'b1;
        new_err = ERR_SHORT;
      end
      dwell_d = DWELL_ONE;
      first_d = 1'b0;
      if (phase_q == PH_PED && cycle_q != '1)
        cycle_d = cycle_q + CNT_W'(1);
    end
  end

  // First error wins unless software acknowledges in the same cycle.
  always_comb begin
    sticky_d = sticky_q;
    code_d   = code_q;
    if (viol_d) begin
      sticky_d = 1'b1;
      if (!sticky_q || clear_err)
        code_d = new_err;
    end else if (clear_err) begin
      sticky_d = 1'b0;
      code_d   = ERR_NONE;
    end
  end

  assign phase       = phase_q;
  assign in_sync     = (state_q == MON_TRACK);
  assign violation   = viol_q;
  assign err_sticky  = sticky_q;
  assign err_code    = code_q;
  assign cycle_count = cycle_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// tb/tb_traffic_light_monitor.sv - directed and random checks of traffic_light_monitor against a sample-history model
module tb_traffic_light_monitor;

  localparam int MIN_D = 3;
  localparam int MAX_D = 3;
  localparam int CNT_MAX = 255;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] main_street;
  logic [1:0] side_street;
  logic       pedestrian_light;
  logic       clear_err;
  logic [2:0] phase;
  logic       in_sync;
  logic       violation;
  logic       err_sticky;
  logic [2:0] err_code;
  logic [7:0] cycle_count;

  traffic_light_monitor #(.MIN_DWELL(MIN_D), .MAX_DWELL(MAX_D), .CNT_W(8)) dut (
    .clk              (clk),
    .reset            (reset),
    .main_street      (main_street),
    .side_street      (side_street),
    .pedestrian_light (pedestrian_light),
    .clear_err        (clear_err),
    .phase            (phase),
    .in_sync          (in_sync),
    .violation        (violation),
    .err_sticky       (err_sticky),
    .err_code         (err_code),
    .cycle_count      (cycle_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int viol_seen = 0;

  int m_locked, m_prev, m_run, m_exempt, m_cycles, m_sticky, m_code, m_viol, m_phase;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Legal buses as a 5-bit {main,side,ped} value: MG=16, MY=8, SG=4, SY=2, PED=1.
  function automatic int model_decode(input logic [4:0] bus);
    case (int'(bus))
      16: return 0;
      8:  return 1;
      4:  return 2;
      2:  return 3;
      1:  return 4;
      default: return -1;
    endcase
  endfunction

  function automatic logic [4:0] enc(input int ph);
    case (ph)
      0: return 5'b10000;
      1: return 5'b01000;
      2: return 5'b00100;
      3: return 5'b00010;
      4: return 5'b00001;
      default: return 5'b11000;
    endcase
  endfunction

  task automatic model_reset();
    m_locked = 0; m_prev = -1; m_run = 0; m_exempt = 0;
    m_cycles = 0; m_sticky = 0; m_code = 0; m_viol = 0; m_phase = 7;
  endtask

  task automatic model_step(input logic [4:0] bus, input bit clr);
    int ph, err;
    ph = model_decode(bus);
    err = 0;
    if (!m_locked) begin
      if (ph >= 0) begin
        m_locked = 1; m_prev = ph; m_run = 1; m_exempt = 1;
      end
    end else if (ph < 0) begin
      err = 1; m_locked = 0; m_run = 0;
    end else if (ph == m_prev) begin
      m_run++;
      if (m_run == MAX_D + 1) err = 4;
    end else if (ph != (m_prev + 1) % 5) begin
      err = 2; m_prev = ph; m_run = 1; m_exempt = 1;
    end else begin
      if (m_run < MIN_D && !m_exempt) err = 3;
      if (m_prev == 4 && m_cycles < CNT_MAX) m_cycles++;
      m_prev = ph; m_run = 1; m_exempt = 0;
    end
    m_viol = (err != 0);
    if (m_viol) begin
      if (!m_sticky || clr) m_code = err;
      m_sticky = 1;
    end else if (clr) begin
      m_sticky = 0; m_code = 0;
    end
    m_phase = (ph < 0) ? 7 : ph;
  endtask

  task automatic compare_all();
    check("phase", phase, m_phase);
    check("in_sync", in_sync, m_locked);
    check("violation", violation, m_viol);
    check("err_sticky", err_sticky, m_sticky);
    check("err_code", err_code, m_code);
    check("cycle_count", cycle_count, m_cycles);
  endtask

  task automatic cycle(input logic [4:0] bus, input bit clr);
    {main_street, side_street, pedestrian_light} = bus;
    clear_err = clr;
    @(posedge clk);
    model_step(bus, clr);
    #1;
    compare_all();
    if (violation === 1'b1) viol_seen++;
    @(negedge clk);
    clear_err = 1'b0;
  endtask

  task automatic hold(input int ph, input int n);
    for (int k = 0; k < n; k++) cycle(enc(ph), 1'b0);
  endtask

  // Asserted mid-way through the low clock phase so no edge precedes the check.
  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int cur, remain, r;
    logic [4:0] bad;
    reset = 1'b1;
    {main_street, side_street, pedestrian_light} = 5'b0;
    clear_err = 1'b0;
    model_reset();
    @(negedge clk);
    compare_all();
    @(negedge clk);
    reset = 1'b0;

    viol_seen = 0;
    for (int i = 0; i < 40; i++) cycle(enc((i / 3) % 5), 1'b0);
    check("nom_cycles", cycle_count, 2);
    check("nom_viol", viol_seen, 0);
    check("nom_sticky", err_sticky, 0);
    do_reset();

    hold(0, 2);
    cycle(5'b11000, 1'b0);
    check("ill_viol", violation, 1);
    check("ill_code", err_code, 1);
    check("ill_sync", in_sync, 0);
    check("ill_phase", phase, 7);
    cycle(enc(1), 1'b0);
    check("ill_resync", in_sync, 1);
    check("ill_noerr", violation, 0);
    cycle(enc(1), 1'b1);
    check("ill_clr", err_sticky, 0);
    do_reset();

    hold(0, 3);
    cycle(enc(2), 1'b0);
    check("ord_viol", violation, 1);
    check("ord_code", err_code, 2);
    check("ord_phase", phase, 2);
    hold(2, 2);
    cycle(enc(3), 1'b0);
    check("ord_exempt", violation, 0);
    do_reset();

    hold(0, 3);
    hold(1, 3);
    hold(2, 2);
    cycle(enc(3), 1'b0);
    check("short_viol", violation, 1);
    check("short_code", err_code, 3);
    cycle(enc(3), 1'b1);
    check("short_clr", err_code, 0);
    viol_seen = 0;
    hold(3, 3);
    check("long_once", viol_seen, 1);
    check("long_code", err_code, 4);
    do_reset();

    hold(0, 3);
    cycle(enc(2), 1'b0);
    check("col_pend", err_code, 2);
    cycle(5'b11000, 1'b1);
    check("col_sticky", err_sticky, 1);
    check("col_code", err_code, 1);
    cycle(5'b11000, 1'b1);
    check("col_clr", err_code, 0);
    do_reset();

    hold(0, 3);
    for (int k = 0; k < 3; k++) begin
      for (int p = 1; p < 5; p++) hold(p, 3);
      hold(0, 3);
    end
    hold(1, 3);
    hold(2, 2);
    check("pre_rst_cycles", cycle_count, 3);
    do_reset();
    cycle(enc(0), 1'b0);
    check("post_rst_viol", violation, 0);
    check("post_rst_sync", in_sync, 1);
    check("post_rst_phase", phase, 0);

    cur = 0;
    remain = 3;
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 99);
      if (r < 4) begin
        do bad = 5'($urandom_range(0, 31)); while (model_decode(bad) >= 0);
        cycle(bad, ($urandom_range(0, 15) == 0));
      end else begin
        if (remain <= 0) begin
          cur = (r < 12) ? $urandom_range(0, 4) : (cur + 1) % 5;
          remain = $urandom_range(1, 5);
        end
        cycle(enc(cur), ($urandom_range(0, 15) == 0));
        remain--;
      end
      if ($urandom_range(0, 299) == 0) do_reset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
